// File: rtl/match_tracker.sv
// Best-of-N match controller: counts round results and detects match end with a winner code.
// Optional macro MATCH_EARLY_STOP_EN ends the match once the outcome is mathematically decided.
module match_tracker #(
  parameter int CNT_W      = 4,
  parameter int MAX_ROUNDS = 9,
  parameter int WIN_TARGET = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             new_match,
  input  logic             round_valid,
  input  logic [1:0]       round_result,
  output logic             round_ready,
  output logic [CNT_W-1:0] round,
  output logic [CNT_W-1:0] win,
  output logic [CNT_W-1:0] lose,
  output logic [CNT_W-1:0] tie,
  output logic             fin,
  output logic             fin_pulse,
  output logic [1:0]       printwinner,
  output logic             err_pulse
);

  if ((MAX_ROUNDS < 1) || (MAX_ROUNDS > (2 ** CNT_W) - 1)) begin : g_bad_max_rounds
    $error("match_tracker: MAX_ROUNDS out of range for CNT_W");
  end
  if ((WIN_TARGET < 1) || (WIN_TARGET > MAX_ROUNDS)) begin : g_bad_win_target
    $error("match_tracker: WIN_TARGET out of range");
  end

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PLAY = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [CNT_W:0]   max_rounds_c = (CNT_W + 1)'(MAX_ROUNDS);
  localparam logic [CNT_W:0]   win_target_c = (CNT_W + 1)'(WIN_TARGET);
  localparam logic [CNT_W-1:0] one_c        = CNT_W'(1);

  state_t           state_r, state_s;
  logic [CNT_W-1:0] round_r, win_r, lose_r, tie_r;
  logic [CNT_W-1:0] round_s, win_s, lose_s, tie_s;
  logic             fin_r, fin_s, fin_pulse_r, fin_pulse_s;
  logic             err_pulse_r, err_pulse_s, round_ready_r;
  logic [1:0]       printwinner_r, printwinner_s;

  // Zero-extended post-update counts so every comparison runs at CNT_W+1 bits.
  logic [CNT_W:0] round_x_s, win_x_s, lose_x_s, rem_s;
  logic           done_s;
  logic [1:0]     code_s;

  // Finish detection on post-update counts; earlier rules take precedence.
  always_comb begin
    round_x_s = {1'b0, round_s};
    win_x_s   = {1'b0, win_s};
    lose_x_s  = {1'b0, lose_s};
    rem_s     = max_rounds_c - round_x_s;
    done_s    = 1'b0;
    code_s    = 2'b00;
    if (win_x_s == win_target_c) begin
      done_s = 1'b1;
      code_s = 2'b01;
    end else if (lose_x_s == win_target_c) begin
      done_s = 1'b1;
      code_s = 2'b10;
    end else if (round_x_s == max_rounds_c) begin
      done_s = 1'b1;
      if (win_x_s > lose_x_s) begin
        code_s = 2'b01;
      end else if (lose_x_s > win_x_s) begin
        code_s = 2'b10;
      end else begin
        code_s = 2'b11;
      end
`ifdef MATCH_EARLY_STOP_EN
    end else if (win_x_s > lose_x_s + rem_s) begin
      done_s = 1'b1;
      code_s = 2'b01;
    end else if (lose_x_s > win_x_s + rem_s) begin
      done_s = 1'b1;
      code_s = 2'b10;
`endif
    end else begin
      done_s = 1'b0;
      code_s = 2'b00;
    end
  end

  // Next-state and next-output logic; new_match overrides any round in the same cycle.
  always_comb begin
    state_s       = state_r;
    round_s       = round_r;
    win_s         = win_r;
    lose_s        = lose_r;
    tie_s         = tie_r;
    fin_s         = fin_r;
    printwinner_s = printwinner_r;
    fin_pulse_s   = 1'b0;
    err_pulse_s   = 1'b0;
    case (state_r)
      PLAY: begin
        if (round_valid) begin
          case (round_result)
            2'b00: begin
              round_s = round_r + one_c;
              tie_s   = tie_r + one_c;
            end
            2'b01: begin
              round_s = round_r + one_c;
              win_s   = win_r + one_c;
            end
            2'b10: begin
              round_s = round_r + one_c;
              lose_s  = lose_r + one_c;
            end
            default: err_pulse_s = 1'b1;
          endcase
          // An illegal result leaves counts unchanged, so it can never newly satisfy a rule.
          if (done_s && !err_pulse_s) begin
            state_s       = DONE;
            fin_s         = 1'b1;
            fin_pulse_s   = 1'b1;
            printwinner_s = code_s;
          end else begin
            state_s = PLAY;
          end
        end else begin
          state_s = PLAY;
        end
      end
      IDLE:    state_s = IDLE;
      DONE:    state_s = DONE;
      default: state_s = IDLE;
    endcase
    if (new_match) begin
      state_s       = PLAY;
      round_s       = {CNT_W{1'b0}};
      win_s         = {CNT_W{1'b0}};
      lose_s        = {CNT_W{1'b0}};
      tie_s         = {CNT_W{1'b0}};
      fin_s         = 1'b0;
      printwinner_s = 2'b00;
      fin_pulse_s   = 1'b0;
      err_pulse_s   = 1'b0;
    end else begin
      state_s = state_s;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      round_r       <= {CNT_W{1'b0}};
      win_r         <= {CNT_W{1'b0}};
      lose_r        <= {CNT_W{1'b0}};
      tie_r         <= {CNT_W{1'b0}};
      fin_r         <= 1'b0;
      fin_pulse_r   <= 1'b0;
      err_pulse_r   <= 1'b0;
      round_ready_r <= 1'b0;
      printwinner_r <= 2'b00;
    end else begin
      state_r       <= state_s;
      round_r       <= round_s;
      win_r         <= win_s;
      lose_r        <= lose_s;
      tie_r         <= tie_s;
      fin_r         <= fin_s;
      fin_pulse_r   <= fin_pulse_s;
      err_pulse_r   <= err_pulse_s;
      round_ready_r <= (state_s == PLAY);
      printwinner_r <= printwinner_s;
    end
  end

  assign round_ready = round_ready_r;
  assign round       = round_r;
  assign win         = win_r;
  assign lose        = lose_r;
  assign tie         = tie_r;
  assign fin         = fin_r;
  assign fin_pulse   = fin_pulse_r;
  assign printwinner = printwinner_r;
  assign err_pulse   = err_pulse_r;

endmodule

// File: tb/tb_match_tracker.sv
// Self-checking bench for match_tracker: integer match model compared every cycle plus literal pins.
module tb_match_tracker;

  logic       clk;
  logic       rst_n;
  logic       new_match;
  logic       round_valid;
  logic [1:0] round_result;
  logic       round_ready;
  logic [3:0] round, win, lose, tie;
  logic       fin, fin_pulse, err_pulse;
  logic [1:0] printwinner;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Model state: plain counts and a phase (0 idle, 1 play, 2 done).
  int m_round = 0, m_win = 0, m_lose = 0, m_tie = 0, m_phase = 0;
  int m_fin = 0, m_finp = 0, m_err = 0, m_pw = 0;

  match_tracker dut (
    .clk(clk), .rst_n(rst_n), .new_match(new_match), .round_valid(round_valid),
    .round_result(round_result), .round_ready(round_ready), .round(round), .win(win),
    .lose(lose), .tie(tie), .fin(fin), .fin_pulse(fin_pulse), .printwinner(printwinner),
    .err_pulse(err_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Match rules from the description: target wins/losses, full length, optional decided-early.
  task automatic model_step(input bit r, input bit nm, input bit rv, input int rr);
    int rem;
    bit done;
    int pw;
    if (!r) begin
      m_round = 0; m_win = 0; m_lose = 0; m_tie = 0; m_phase = 0;
      m_fin = 0; m_finp = 0; m_err = 0; m_pw = 0;
      return;
    end
    m_finp = 0;
    m_err  = 0;
    if (nm) begin
      m_round = 0; m_win = 0; m_lose = 0; m_tie = 0; m_phase = 1;
      m_fin = 0; m_pw = 0;
    end else if (m_phase == 1 && rv) begin
      if (rr == 3) begin
        m_err = 1;
      end else begin
        m_round++;
        if (rr == 0) m_tie++;
        else if (rr == 1) m_win++;
        else m_lose++;
        rem  = 9 - m_round;
        done = 1'b1;
        if (m_win == 5) pw = 1;
        else if (m_lose == 5) pw = 2;
        else if (m_round == 9) pw = (m_win > m_lose) ? 1 : (m_lose > m_win) ? 2 : 3;
`ifdef MATCH_EARLY_STOP_EN
        else if (m_win > m_lose + rem) pw = 1;
        else if (m_lose > m_win + rem) pw = 2;
`endif
        else begin
          done = 1'b0;
          pw   = 0;
        end
        if (done) begin
          m_phase = 2; m_fin = 1; m_finp = 1; m_pw = pw;
        end
      end
    end
  endtask

  // One clock: apply inputs, take the edge, advance the model.
  task automatic cyc(input bit r, input bit nm, input bit rv, input logic [1:0] rr);
    rst_n = r; new_match = nm; round_valid = rv; round_result = rr;
    @(posedge clk);
    model_step(r, nm, rv, int'(rr));
    #1;
    new_match = 1'b0; round_valid = 1'b0; round_result = 2'b00; rst_n = 1'b1;
  endtask

  // Compare process: DUT against the model on every falling edge once reset has been applied.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("round", 32'(round), 32'(m_round));
      chk("win", 32'(win), 32'(m_win));
      chk("lose", 32'(lose), 32'(m_lose));
      chk("tie", 32'(tie), 32'(m_tie));
      chk("fin", 32'(fin), 32'(m_fin));
      chk("fin_pulse", 32'(fin_pulse), 32'(m_finp));
      chk("err_pulse", 32'(err_pulse), 32'(m_err));
      chk("printwinner", 32'(printwinner), 32'(m_pw));
      chk("round_ready", 32'(round_ready), 32'(m_phase == 1));
    end
  end

  initial begin
    rst_n = 1'b0; new_match = 1'b0; round_valid = 1'b0; round_result = 2'b00;
    cyc(1'b0, 1'b0, 1'b0, 2'b00);
    cyc(1'b0, 1'b0, 1'b0, 2'b00);
    chk_en = 1'b1;
    chk("reset_ready", 32'(round_ready), 32'd0);
    chk("reset_pw", 32'(printwinner), 32'd0);

    // 1: five straight wins
    cyc(1'b1, 1'b1, 1'b0, 2'b00);
    chk("t1_ready", 32'(round_ready), 32'd1);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b1, 2'b01);
    chk("t1_win", 32'(win), 32'd5);
    chk("t1_round", 32'(round), 32'd5);
    chk("t1_fin", 32'(fin), 32'd1);
    chk("t1_finp", 32'(fin_pulse), 32'd1);
    chk("t1_pw", 32'(printwinner), 32'd1);
    chk("t1_ready_done", 32'(round_ready), 32'd0);
    // 4b: round_valid in DONE is ignored
    cyc(1'b1, 1'b0, 1'b1, 2'b11);
    chk("t1_finp_drop", 32'(fin_pulse), 32'd0);
    chk("t4_done_err", 32'(err_pulse), 32'd0);
    cyc(1'b1, 1'b0, 1'b1, 2'b10);
    chk("t4_done_lose", 32'(lose), 32'd0);

    // 2: alternating then a tie -> full-length draw
    cyc(1'b1, 1'b1, 1'b0, 2'b00);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0, 1'b1, 2'b01);
      cyc(1'b1, 1'b0, 1'b1, 2'b10);
    end
    cyc(1'b1, 1'b0, 1'b1, 2'b00);
    chk("t2_round", 32'(round), 32'd9);
    chk("t2_tie", 32'(tie), 32'd1);
    chk("t2_pw", 32'(printwinner), 32'd3);
    chk("t2_fin", 32'(fin), 32'd1);

    // 3: decided lead with ties
    cyc(1'b1, 1'b1, 1'b0, 2'b00);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b1, 2'b01);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b1, 2'b00);
`ifdef MATCH_EARLY_STOP_EN
    chk("t3_fin_early", 32'(fin), 32'd1);
    chk("t3_round_early", 32'(round), 32'd7);
    chk("t3_pw_early", 32'(printwinner), 32'd1);
`else
    chk("t3_fin_late", 32'(fin), 32'd0);
    chk("t3_ready", 32'(round_ready), 32'd1);
    cyc(1'b1, 1'b0, 1'b1, 2'b10);
    cyc(1'b1, 1'b0, 1'b1, 2'b10);
    chk("t3_round9", 32'(round), 32'd9);
    chk("t3_fin9", 32'(fin), 32'd1);
    chk("t3_pw9", 32'(printwinner), 32'd1);
`endif

    // 4: illegal result
    cyc(1'b1, 1'b1, 1'b0, 2'b00);
    cyc(1'b1, 1'b0, 1'b1, 2'b01);
    cyc(1'b1, 1'b0, 1'b1, 2'b11);
    chk("t4_err", 32'(err_pulse), 32'd1);
    chk("t4_round", 32'(round), 32'd1);
    cyc(1'b1, 1'b0, 1'b0, 2'b00);
    chk("t4_err_drop", 32'(err_pulse), 32'd0);

    // 5: new_match beats a simultaneous round
    cyc(1'b1, 1'b1, 1'b0, 2'b00);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b1, 2'b01);
    chk("t5_win3", 32'(win), 32'd3);
    cyc(1'b1, 1'b1, 1'b1, 2'b01);
    chk("t5_win", 32'(win), 32'd0);
    chk("t5_round", 32'(round), 32'd0);
    chk("t5_ready", 32'(round_ready), 32'd1);

    // 6: reset mid-match wins over new_match
    cyc(1'b1, 1'b0, 1'b1, 2'b01);
    cyc(1'b1, 1'b0, 1'b1, 2'b10);
    cyc(1'b1, 1'b0, 1'b1, 2'b00);
    cyc(1'b1, 1'b0, 1'b1, 2'b01);
    chk("t6_round4", 32'(round), 32'd4);
    cyc(1'b0, 1'b1, 1'b1, 2'b01);
    chk("t6_round", 32'(round), 32'd0);
    chk("t6_ready", 32'(round_ready), 32'd0);
    cyc(1'b1, 1'b0, 1'b1, 2'b01);
    chk("t6_ignored", 32'(win), 32'd0);
    cyc(1'b1, 1'b1, 1'b0, 2'b00);
    cyc(1'b1, 1'b0, 1'b1, 2'b10);
    chk("t6_lose", 32'(lose), 32'd1);
    cyc(1'b1, 1'b0, 1'b0, 2'b00);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/match_tracker.md
# match_tracker

Sequential best-of-N match controller for the game datapath. Accepts one round result per handshake, keeps registered round/win/lose/tie counts, and detects match end with a winner code. Detection rules are parameterised on match length and win target. It sits between the round-judge logic and the display/print stage, and drives `fin` and `printwinner` directly.

## Interface
Parameters:
- `CNT_W`, default 4: width of every counter output.
- `MAX_ROUNDS`, default 9: rounds in a full match, ties included. Must satisfy 1 ≤ MAX_ROUNDS ≤ 2**CNT_W−1 (elaboration `$error` otherwise).
- `WIN_TARGET`, default 5: wins (or losses) that end the match immediately. Must satisfy 1 ≤ WIN_TARGET ≤ MAX_ROUNDS.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `new_match`  in  1  clears counts and starts a match.
- `round_valid`  in  1  `round_result` is valid this cycle.
- `round_result`  in  2  00 tie, 01 player win, 10 player lose, 11 illegal.
- `round_ready`  out  1  high only in PLAY.
- `round`  out  CNT_W  rounds played.
- `win`  out  CNT_W  player wins.
- `lose`  out  CNT_W  player losses.
- `tie`  out  CNT_W  tied rounds.
- `fin`  out  1  match finished (level).
- `fin_pulse`  out  1  one-cycle strobe on entry to DONE.
- `printwinner`  out  2  00 none yet, 01 player, 10 opponent, 11 draw.
- `err_pulse`  out  1  one-cycle strobe on an illegal accepted result.

## Operation
States:
- IDLE (reset state).
- PLAY.
- DONE.

Reset (`rst_n`=0 at a clock edge):
- State goes to IDLE.
- All counters = 0.
- `fin`, `fin_pulse`, `err_pulse`, `round_ready` = 0.
- `printwinner` = 00.

Transitions:
- `new_match`=1 in any state: counters cleared, `fin`=0, `printwinner`=00, next state PLAY. `new_match` has priority over `round_valid` in the same cycle, and that round is dropped.
- In PLAY, a round is accepted when `round_valid` && `round_ready`:
  - 00 → `round`+1, `tie`+1.
  - 01 → `round`+1, `win`+1.
  - 10 → `round`+1, `lose`+1.
  - 11 → no counter change, `err_pulse`=1 next cycle.
- `round_valid` in IDLE or DONE is ignored: no count, no error.

Finish checks use post-update values (`rem` = MAX_ROUNDS − `round`):
- `win` == WIN_TARGET → DONE, `printwinner`=01.
- `lose` == WIN_TARGET → DONE, `printwinner`=10.
- `round` == MAX_ROUNDS → DONE. `printwinner` = 01 if win>lose, 10 if lose>win, 11 if equal.
- Early-stop rule (see Configuration).

Other rules:
- DONE holds all outputs until `new_match` or reset.
- Counters never wrap; the finish rules guarantee `round` ≤ MAX_ROUNDS.
- Invariant: `round` == `win` + `lose` + `tie`.
- Comparisons are unsigned at CNT_W+1 bits to avoid overflow in `lose` + `rem`.

## Timing
- All outputs are registered.
- Counters update on the edge that accepts the round.
- `fin`, `printwinner` and `fin_pulse` assert on that same edge (zero extra latency).
- `fin_pulse` and `err_pulse` are high for exactly one cycle.
- `round_ready` deasserts on the edge entering DONE, so throughput is one round per cycle until finish.
- Reset mid-match wins over every other input, including a simultaneous `new_match`.

## Configuration
Macro `MATCH_EARLY_STOP_EN`:
- Defined: the match also ends when the result is mathematically decided.
  - `win` > `lose` + `rem` → DONE, `printwinner`=01.
  - `lose` > `win` + `rem` → DONE, `printwinner`=10.
- Undefined: the match ends only on WIN_TARGET or MAX_ROUNDS.

## Test plan
Defaults throughout (CNT_W=4, MAX_ROUNDS=9, WIN_TARGET=5).
1. Reset then `new_match` → all counters 0, `round_ready`=1. Five consecutive 01 results → on the 5th edge `win`=5, `round`=5, `fin`=1, `fin_pulse` for one cycle, `printwinner`=01.
2. Sequence 01,10 ×4 then 00 → `round`=9, `win`=4, `lose`=4, `tie`=1, `fin`=1, `printwinner`=11.
3. Sequence 01,01,01,00,00,00,00 → with `MATCH_EARLY_STOP_EN`: `fin`=1 at `round`=7, `printwinner`=01. Without it: `fin`=0, `round_ready`=1, two further 10 results end the match at round 9 with `printwinner`=01.
4. Result 11 during PLAY → counters unchanged, `err_pulse`=1 for one cycle. `round_valid` while in DONE → counters unchanged, no error.
5. `new_match` and `round_valid`=01 in the same cycle at `win`=3 → `win`=0, `round`=0, state PLAY.
6. `rst_n`=0 for one edge mid-match (`round`=4) → all outputs 0, state IDLE. A following `round_valid` is ignored until `new_match`.
